// File: rtl/conv_mac_engine_if.sv
// Handshake and operand bundle between the window generator, the MAC engine
// and the feature-map writeback.
interface conv_mac_engine_if #(
  parameter int K     = 5,
  parameter int DW    = 8,
  parameter int ACC_W = 32,
  parameter int OUT_W = 8
);
  localparam int N = K * K;

  logic                    start;
  logic                    start_ready;
  logic [N*DW-1:0]         win_i;
  logic [N*DW-1:0]         wgt_i;
  logic signed [ACC_W-1:0] bias_i;
  logic                    relu_en;
  logic [4:0]              shift_i;
  logic                    busy;
  logic signed [ACC_W-1:0] acc_o;
  logic signed [OUT_W-1:0] q_o;
  logic                    out_valid;
  logic                    out_ready;

  modport master (
    output start, win_i, wgt_i, bias_i, relu_en, shift_i, out_ready,
    input  start_ready, busy, acc_o, q_o, out_valid
  );

  modport slave (
    input  start, win_i, wgt_i, bias_i, relu_en, shift_i, out_ready,
    output start_ready, busy, acc_o, q_o, out_valid
  );
endinterface

// File: rtl/conv_mac_engine.sv
// KxK signed window dot product plus bias with LANES products per cycle,
// followed by optional ReLU, arithmetic-shift requantisation and saturation.
module conv_mac_engine #(
  parameter int K     = 5,
  parameter int DW    = 8,
  parameter int ACC_W = 32,
  parameter int LANES = 1,
  parameter int OUT_W = 8
) (
  input logic               clk,
  input logic               rst,
  conv_mac_engine_if.slave  bus
);
  localparam int N     = K * K;
  localparam int BEATS = (N + LANES - 1) / LANES;
  localparam int NP    = BEATS * LANES;
  localparam int IW    = (NP > 1) ? $clog2(NP) : 1;
  localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic signed [ACC_W-1:0] Q_MAX = {{(ACC_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] Q_MIN = {{(ACC_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, HOLD = 2'd2} state_t;

  state_t                  state_q, state_d;
  logic [BW-1:0]           beat_q, beat_d;
  // Operand copies are padded to BEATS*LANES with zeros so tail lanes add nothing.
  logic signed [DW-1:0]    win_q [NP];
  logic signed [DW-1:0]    win_d [NP];
  logic signed [DW-1:0]    wgt_q [NP];
  logic signed [DW-1:0]    wgt_d [NP];
  logic                    relu_q, relu_d;
  logic [4:0]              shift_q, shift_d;
  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic signed [ACC_W-1:0] acc_o_q, acc_o_d;
  logic signed [OUT_W-1:0] q_o_q, q_o_d;
  logic                    out_valid_q, out_valid_d;
  logic                    start_ready_q, start_ready_d;
  logic                    busy_q, busy_d;

  logic [IW-1:0]           idx;
  logic signed [2*DW-1:0]  prod;
  logic signed [ACC_W-1:0] lane_sum;
  logic signed [ACC_W-1:0] acc_next;
  logic signed [ACC_W-1:0] relu_val;
  logic signed [ACC_W-1:0] shifted;
  logic signed [OUT_W-1:0] q_next;

  assign bus.start_ready = start_ready_q;
  assign bus.busy        = busy_q;
  assign bus.acc_o       = acc_o_q;
  assign bus.q_o         = q_o_q;
  assign bus.out_valid   = out_valid_q;

  // Sum of this beat's lane products and the requantised view of the new total.
  always_comb begin
    idx      = '0;
    prod     = '0;
    lane_sum = '0;
    for (int j = 0; j < LANES; j++) begin
      idx      = IW'(int'(beat_q) * LANES + j);
      prod     = win_q[idx] * wgt_q[idx];
      lane_sum = lane_sum + {{(ACC_W-2*DW){prod[2*DW-1]}}, prod};
    end
    acc_next = acc_q + lane_sum;
    relu_val = (relu_q && acc_next[ACC_W-1]) ? '0 : acc_next;
    shifted  = relu_val >>> shift_q;
    q_next   = (shifted > Q_MAX) ? Q_MAX[OUT_W-1:0] :
               (shifted < Q_MIN) ? Q_MIN[OUT_W-1:0] : shifted[OUT_W-1:0];
  end

  // Next-state and next-output computation for the IDLE/RUN/HOLD sequencer.
  always_comb begin
    state_d       = state_q;
    beat_d        = beat_q;
    win_d         = win_q;
    wgt_d         = wgt_q;
    relu_d        = relu_q;
    shift_d       = shift_q;
    acc_d         = acc_q;
    acc_o_d       = acc_o_q;
    q_o_d         = q_o_q;
    out_valid_d   = out_valid_q;
    start_ready_d = start_ready_q;
    busy_d        = busy_q;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          for (int i = 0; i < N; i++) begin
            win_d[i] = bus.win_i[i*DW +: DW];
            wgt_d[i] = bus.wgt_i[i*DW +: DW];
          end
          for (int i = N; i < NP; i++) begin
            win_d[i] = '0;
            wgt_d[i] = '0;
          end
          relu_d        = bus.relu_en;
          shift_d       = bus.shift_i;
          acc_d         = bus.bias_i;
          beat_d        = '0;
          state_d       = RUN;
          start_ready_d = 1'b0;
          busy_d        = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        acc_d = acc_next;
        if (beat_q == BW'(BEATS - 1)) begin
          state_d     = HOLD;
          acc_o_d     = acc_next;
          q_o_d       = q_next;
          out_valid_d = 1'b1;
        end else begin
          beat_d = beat_q + 1'b1;
        end
      end
      HOLD: begin
        // start is deliberately not looked at here, even on the transfer edge.
        if (bus.out_ready) begin
          out_valid_d   = 1'b0;
          state_d       = IDLE;
          start_ready_d = 1'b1;
          busy_d        = 1'b0;
        end else begin
          state_d = HOLD;
        end
      end
      default: begin
        state_d       = IDLE;
        out_valid_d   = 1'b0;
        start_ready_d = 1'b1;
        busy_d        = 1'b0;
      end
    endcase
  end

  // State and output registers; rst wins over every other input.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      beat_q        <= '0;
      for (int i = 0; i < NP; i++) begin
        win_q[i] <= '0;
        wgt_q[i] <= '0;
      end
      relu_q        <= 1'b0;
      shift_q       <= 5'd0;
      acc_q         <= '0;
      acc_o_q       <= '0;
      q_o_q         <= '0;
      out_valid_q   <= 1'b0;
      start_ready_q <= 1'b1;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      beat_q        <= beat_d;
      win_q         <= win_d;
      wgt_q         <= wgt_d;
      relu_q        <= relu_d;
      shift_q       <= shift_d;
      acc_q         <= acc_d;
      acc_o_q       <= acc_o_d;
      q_o_q         <= q_o_d;
      out_valid_q   <= out_valid_d;
      start_ready_q <= start_ready_d;
      busy_q        <= busy_d;
    end
  end
endmodule

// File: tb/tb_conv_mac_engine.sv
// Bench for conv_mac_engine: a LANES=1 and a LANES=4 instance run the same
// operations and are compared against a plain-arithmetic dot-product model.
module tb_conv_mac_engine;
  localparam int K = 5, DW = 8, ACC_W = 32, OUT_W = 8;
  localparam int N = K * K;
  localparam int BEATS_A = N;
  localparam int BEATS_B = (N + 3) / 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic              start, relu_v, out_ready;
  logic [N*DW-1:0]   win_v, wgt_v;
  logic [ACC_W-1:0]  bias_v;
  logic [4:0]        shift_v;

  conv_mac_engine_if #(.K(K), .DW(DW), .ACC_W(ACC_W), .OUT_W(OUT_W)) bus_a ();
  conv_mac_engine_if #(.K(K), .DW(DW), .ACC_W(ACC_W), .OUT_W(OUT_W)) bus_b ();

  assign bus_a.start = start;     assign bus_b.start = start;
  assign bus_a.win_i = win_v;     assign bus_b.win_i = win_v;
  assign bus_a.wgt_i = wgt_v;     assign bus_b.wgt_i = wgt_v;
  assign bus_a.bias_i = bias_v;   assign bus_b.bias_i = bias_v;
  assign bus_a.relu_en = relu_v;  assign bus_b.relu_en = relu_v;
  assign bus_a.shift_i = shift_v; assign bus_b.shift_i = shift_v;
  assign bus_a.out_ready = out_ready;
  assign bus_b.out_ready = out_ready;

  conv_mac_engine #(.K(K), .DW(DW), .ACC_W(ACC_W), .LANES(1), .OUT_W(OUT_W))
    dut_a (.clk(clk), .rst(rst), .bus(bus_a));
  conv_mac_engine #(.K(K), .DW(DW), .ACC_W(ACC_W), .LANES(4), .OUT_W(OUT_W))
    dut_b (.clk(clk), .rst(rst), .bus(bus_b));

  int n_checks = 0;
  int n_pass   = 0;
  int w_a [N];
  int g_a [N];
  int bias_m, shift_m;
  bit relu_m;

  task automatic check_val(input string tag, input longint obs, input longint exp);
    n_checks++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: wrap-around 32-bit dot product plus bias.
  function automatic longint ref_acc();
    longint s;
    int r;
    s = bias_m;
    for (int i = 0; i < N; i++) s += longint'(w_a[i]) * longint'(g_a[i]);
    r = int'(s);
    return longint'(r);
  endfunction

  function automatic longint ref_q(input longint acc);
    longint t;
    t = (relu_m && acc < 0) ? 0 : acc;
    t = t >>> shift_m;
    if (t > 127) t = 127;
    if (t < -128) t = -128;
    return t;
  endfunction

  task automatic drive_ops();
    for (int i = 0; i < N; i++) begin
      win_v[i*DW +: DW] = DW'(w_a[i]);
      wgt_v[i*DW +: DW] = DW'(g_a[i]);
    end
    bias_v  = ACC_W'(bias_m);
    relu_v  = relu_m;
    shift_v = 5'(shift_m);
  endtask

  task automatic scramble();
    for (int i = 0; i < N; i++) begin
      win_v[i*DW +: DW] = 8'($urandom);
      wgt_v[i*DW +: DW] = 8'($urandom);
    end
    bias_v  = $urandom;
    relu_v  = 1'($urandom);
    shift_v = 5'($urandom);
  endtask

  task automatic random_ops();
    for (int i = 0; i < N; i++) begin
      w_a[i] = int'($urandom_range(0, 255)) - 128;
      g_a[i] = int'($urandom_range(0, 255)) - 128;
    end
    bias_m  = int'($urandom);
    relu_m  = 1'($urandom);
    shift_m = int'($urandom_range(0, 31));
  endtask

  task automatic fill_ops(input int wv, input int gv, input int b, input bit rl, input int sh);
    for (int i = 0; i < N; i++) begin
      w_a[i] = wv;
      g_a[i] = gv;
    end
    bias_m = b; relu_m = rl; shift_m = sh;
  endtask

  // One operation with out_ready high; operands scrambled after the capture edge.
  task automatic run_op(input string name);
    longint ea, eq;
    int lat_a, lat_b, cnt_a, cnt_b;
    ea = ref_acc();
    eq = ref_q(ea);
    lat_a = -1; lat_b = -1; cnt_a = 0; cnt_b = 0;
    out_ready = 1'b1;
    drive_ops();
    start = 1'b1;
    tick();
    start = 1'b0;
    check_val({name, "/busy_a"}, bus_a.busy, 1);
    check_val({name, "/sready_b"}, bus_b.start_ready, 0);
    for (int n = 2; n <= 40; n++) begin
      scramble();
      tick();
      if (bus_a.out_valid) begin
        cnt_a++;
        if (lat_a < 0) begin
          lat_a = n;
          check_val({name, "/acc_a"}, bus_a.acc_o, ea);
          check_val({name, "/q_a"}, bus_a.q_o, eq);
        end
      end
      if (bus_b.out_valid) begin
        cnt_b++;
        if (lat_b < 0) begin
          lat_b = n;
          check_val({name, "/acc_b"}, bus_b.acc_o, ea);
          check_val({name, "/q_b"}, bus_b.q_o, eq);
        end
      end
    end
    check_val({name, "/lat_a"}, lat_a, BEATS_A + 1);
    check_val({name, "/lat_b"}, lat_b, BEATS_B + 1);
    check_val({name, "/vcnt_a"}, cnt_a, 1);
    check_val({name, "/vcnt_b"}, cnt_b, 1);
    check_val({name, "/sready_a"}, bus_a.start_ready, 1);
    check_val({name, "/hold_acc_a"}, bus_a.acc_o, ea);
  endtask

  // Stall the output for 10 cycles while start and operands toggle.
  task automatic bp_op();
    longint ea, eq;
    int guard;
    ea = ref_acc();
    eq = ref_q(ea);
    out_ready = 1'b0;
    drive_ops();
    start = 1'b1;
    tick();
    start = 1'b0;
    guard = 0;
    while (!bus_a.out_valid && guard < 60) begin
      tick();
      guard++;
    end
    check_val("bp/reach_valid", bus_a.out_valid, 1);
    for (int c = 0; c < 10; c++) begin
      start = ~start;
      scramble();
      tick();
      check_val("bp/valid_a", bus_a.out_valid, 1);
      check_val("bp/valid_b", bus_b.out_valid, 1);
      check_val("bp/acc_a", bus_a.acc_o, ea);
      check_val("bp/q_b", bus_b.q_o, eq);
      check_val("bp/sready_a", bus_a.start_ready, 0);
    end
    start = 1'b1;
    out_ready = 1'b1;
    tick();
    check_val("bp/xfer_valid_a", bus_a.out_valid, 0);
    check_val("bp/xfer_valid_b", bus_b.out_valid, 0);
    check_val("bp/xfer_sready_a", bus_a.start_ready, 1);
    start = 1'b0;
    tick();
    check_val("bp/start_dropped_a", bus_a.busy, 0);
    check_val("bp/start_dropped_b", bus_b.busy, 0);
  endtask

  initial begin
    bit seen;
    rst = 1'b1; start = 1'b0; out_ready = 1'b1;
    fill_ops(0, 0, 0, 1'b0, 0);
    drive_ops();
    tick();
    tick();
    check_val("rst/acc_a", bus_a.acc_o, 0);
    check_val("rst/q_b", bus_b.q_o, 0);
    check_val("rst/valid_a", bus_a.out_valid, 0);
    check_val("rst/busy_b", bus_b.busy, 0);
    check_val("rst/sready_a", bus_a.start_ready, 1);
    rst = 1'b0;
    tick();

    fill_ops(1, 1, 0, 1'b0, 0);
    run_op("ones");
    fill_ops(0, 1, 10, 1'b0, 2);
    for (int i = 0; i < N; i++) w_a[i] = i;
    run_op("ramp");
    fill_ops(127, 127, 0, 1'b0, 0);
    run_op("sat_pos");
    fill_ops(127, -128, 0, 1'b0, 0);
    run_op("sat_neg");
    fill_ops(127, -128, 0, 1'b1, 0);
    run_op("sat_relu");

    random_ops();
    bp_op();

    // Abort mid-RUN at beat 12 of the single-lane instance.
    random_ops();
    drive_ops();
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (12) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_val("abort/valid_a", bus_a.out_valid, 0);
    check_val("abort/sready_a", bus_a.start_ready, 1);
    check_val("abort/busy_a", bus_a.busy, 0);
    seen = 1'b0;
    for (int c = 0; c < 30; c++) begin
      tick();
      if (bus_a.out_valid || bus_b.out_valid) seen = 1'b1;
    end
    check_val("abort/no_valid", seen, 0);
    random_ops();
    run_op("after_abort");

    for (int r = 0; r < 20; r++) begin
      random_ops();
      run_op($sformatf("rand%0d", r));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/conv_mac_engine.md
Name: conv_mac_engine

Overview:
- Parametrised successor to the single-lane 5x5 convolution window unit.
- Computes one KxK signed dot product (window x weights) plus bias, using LANES multipliers per cycle.
- Applies optional ReLU, arithmetic right-shift requantisation and saturation.
- Presents the raw and quantised results on a valid/ready output handshake.
- Sits between the line-buffer/window generator and the feature-map writeback.

Parameters:
- K, 5, kernel side length; the window holds N = K*K elements.
- DW, 8, signed width of each window and weight element.
- ACC_W, 32, signed width of the accumulator and bias.
- LANES, 1, products summed per RUN cycle; must satisfy 1 <= LANES <= N.
- OUT_W, 8, signed width of the quantised output.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- start  in  1  start request; accepted only while start_ready=1.
- start_ready  out  1  high exactly when state==IDLE.
- win_i  in  N*DW  flattened window; element i is at bits [i*DW +: DW], row-major (i = r*K + c).
- wgt_i  in  N*DW  flattened weights, same layout as win_i.
- bias_i  in  ACC_W  signed bias.
- relu_en  in  1  enables ReLU.
- shift_i  in  5  arithmetic right-shift amount.
- busy  out  1  high when state is not IDLE.
- acc_o  out  ACC_W  raw accumulator result (bias included).
- q_o  out  OUT_W  requantised, saturated result.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accept.

Behaviour:
- Reset values: state=IDLE, acc_o=0, q_o=0, out_valid=0, busy=0, start_ready=1, beat counter=0.
- rst has priority over all other inputs in every state.
- A reset mid-RUN or mid-HOLD aborts the operation with no output.
- State machine has three states: IDLE, RUN, HOLD. BEATS = ceil(N/LANES).
- IDLE:
  - On start=1, capture win_i, wgt_i, bias_i, relu_en and shift_i into internal registers.
  - Load accumulator with bias; set beat=0; go to RUN.
  - Operand inputs are don't-care after the capture edge.
- RUN:
  - Each cycle, acc += sum over lanes j of win[b*LANES+j] * wgt[b*LANES+j], where b is the beat counter.
  - A lane whose index is >= N contributes 0 (tail masking on the last beat).
  - Each product is a signed 2*DW-bit value, sign-extended to ACC_W.
  - The accumulator wraps modulo 2^ACC_W and does not saturate.
  - On the beat b==BEATS-1, go to HOLD and register the outputs on the same edge.
- Output computation:
  - acc_o = final accumulator value.
  - t = relu_en ? max(acc,0) : acc.
  - s = t >>> shift_i (arithmetic shift).
  - q_o = clamp(s, -2^(OUT_W-1), 2^(OUT_W-1)-1).
- HOLD:
  - out_valid=1; acc_o and q_o hold stable until out_valid && out_ready.
  - On that transfer edge: out_valid <= 0, go to IDLE.
  - start is ignored in HOLD, including in the transfer cycle; start_ready=0 throughout HOLD.
- start while busy is dropped; it is not queued.
- Latency: start sampled in cycle T → RUN occupies cycles T+1..T+BEATS → out_valid first high in cycle T+BEATS+1.
- If out_ready is held high, the next start is accepted in cycle T+BEATS+2 at the earliest.
- acc_o and q_o keep their last values in IDLE; only out_valid qualifies them.

Test Plan:
- K=5, LANES=1, all win=1, all wgt=1, bias=0, shift=0, out_ready=1, start in cycle T → out_valid in cycle T+26 for one cycle, acc_o=25, q_o=25, then start_ready=1.
- K=5, LANES=4 (BEATS=7), win[i]=i, wgt=1, bias=10, shift=2 → acc_o=310, q_o=77, out_valid at T+8; confirms tail lanes 25..27 are masked.
- Saturation: win=127, wgt=127, bias=0 → acc_o=403225, q_o=127. With wgt=-128 → acc_o=-406400, q_o=-128. Same with relu_en=1 → acc_o=-406400, q_o=0.
- Backpressure: hold out_ready=0 for 10 cycles after out_valid, pulse start and change win_i meanwhile → out_valid, acc_o and q_o stay stable, start is ignored. Raise out_ready → transfer, then IDLE next cycle.
- Operand isolation: change win_i, wgt_i and bias_i every cycle after the start edge → result equals the computation on the captured values.
- Reset mid-RUN at beat 12, then start with new operands → no out_valid from the aborted op; new result correct with standard latency.
